// File: rtl/sensor_rx_pkg.sv
// Shared parameters and types for the sensor frame receiver.
// Geometry is fixed here so the bank and the top agree on widths.
package sensor_rx_pkg;

  localparam int PIXEL_BITS = 8;
  localparam int BUS_PIXELS = 8;
  localparam int ROW_PIXELS = 24;
  localparam int ROWS       = 3;
  localparam int BEATS      = ROW_PIXELS / BUS_PIXELS;
  localparam int BUS_W      = BUS_PIXELS * PIXEL_BITS;

  localparam int ROW_W    = $clog2(ROWS);
  localparam int COL_W    = $clog2(ROW_PIXELS);
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  // Row counter must be able to hold ROWS itself (the "frame full" value).
  localparam int ROWCNT_W = $clog2(ROWS + 1);

  localparam logic [ROWCNT_W-1:0] ROWS_FULL = ROWCNT_W'(ROWS);
  localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef logic [PIXEL_BITS-1:0] pixel_t;

  typedef enum logic {
    CAPTURE = 1'b0,
    DROP    = 1'b1
  } wr_state_e;

endpackage

// File: rtl/sensor_frame_bank.sv
// One frame buffer: beat-wide write port, combinational pixel read port.
// Out-of-range read addresses return zero.
module sensor_frame_bank
  import sensor_rx_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [BEAT_W-1:0] wr_beat,
  input  logic [BUS_W-1:0]  wr_data,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output pixel_t            rd_pixel
);

  logic [ROW_PIXELS*PIXEL_BITS-1:0] row_q [ROWS];
  logic [ROW_PIXELS*PIXEL_BITS-1:0] row_d [ROWS];
  logic                             rd_in_range;

  always_comb begin
    row_d = row_q;
    if (wr_en) begin
      row_d[wr_row][wr_beat*BUS_W +: BUS_W] = wr_data;
    end
  end

  // Contents are don't-care after reset, so no reset on the storage.
  always_ff @(posedge clk) begin
    row_q <= row_d;
  end

  always_comb begin
    rd_in_range = ({1'b0, rd_row} < (ROW_W+1)'(ROWS)) &&
                  ({1'b0, rd_col} < (COL_W+1)'(ROW_PIXELS));
    rd_pixel    = '0;
    if (rd_in_range) begin
      rd_pixel = row_q[rd_row][rd_col*PIXEL_BITS +: PIXEL_BITS];
    end
  end

endmodule

// File: rtl/sensor_frame_receiver.sv
// Reassembles sensor bus beats into frames stored in a ping-pong pair of
// banks; the consumer reads one bank while the other is being filled.
module sensor_frame_receiver
  import sensor_rx_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_valid,
  input  logic [BUS_W-1:0] rx_data,
  input  logic             rx_frame_end,
  input  logic             rd_en,
  input  logic [ROW_W-1:0] rd_row,
  input  logic [COL_W-1:0] rd_col,
  output pixel_t           rd_data,
  output logic             rd_valid,
  output logic             frame_ready,
  input  logic             frame_release,
  input  logic             clear_status,
  output logic             overrun,
  output logic             frame_error
);

  // Interfaces carry no backpressure: rx_valid is a one-cycle beat strobe
  // that is always consumed, and rd_en is answered exactly one cycle later
  // with rd_valid (data only when a complete frame is ready).

  wr_state_e             state_q, state_d, cur_state;
  logic                  started_q, started_d;
  logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [ROWCNT_W-1:0]   row_cnt_q, row_cnt_d;
  logic                  bad_q, bad_d;
  logic                  wbank_q, wbank_d;
  logic                  rbank_q, rbank_d;
  logic [1:0]            full_q, full_d;
  logic                  frame_ready_q, frame_ready_d;
  logic                  rd_valid_q, rd_valid_d;
  pixel_t                rd_data_q, rd_data_d;
  logic                  overrun_q, overrun_d;
  logic                  frame_error_q, frame_error_d;

  logic                  beat_wr;
  logic                  complete;
  logic                  overrun_set;
  logic                  error_set;
  pixel_t                bank_pix [2];

  sensor_frame_bank u_bank0 (
    .clk      (clk),
    .wr_en    (beat_wr && !wbank_q),
    .wr_row   (ROW_W'(row_cnt_q)),
    .wr_beat  (beat_cnt_q),
    .wr_data  (rx_data),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .rd_pixel (bank_pix[0])
  );

  sensor_frame_bank u_bank1 (
    .clk      (clk),
    .wr_en    (beat_wr && wbank_q),
    .wr_row   (ROW_W'(row_cnt_q)),
    .wr_beat  (beat_cnt_q),
    .wr_data  (rx_data),
    .rd_row   (rd_row),
    .rd_col   (rd_col),
    .rd_pixel (bank_pix[1])
  );

  always_comb begin
    // Capture vs drop is decided once, on the first beat of each frame.
    cur_state     = started_q ? state_q : (full_q[wbank_q] ? DROP : CAPTURE);
    state_d       = state_q;
    started_d     = started_q;
    beat_cnt_d    = beat_cnt_q;
    row_cnt_d     = row_cnt_q;
    bad_d         = bad_q;
    wbank_d       = wbank_q;
    rbank_d       = rbank_q;
    full_d        = full_q;
    beat_wr       = 1'b0;
    complete      = 1'b0;
    overrun_set   = 1'b0;
    error_set     = 1'b0;

    if (rx_valid) begin
      started_d = 1'b1;
      state_d   = cur_state;
      if (row_cnt_q == ROWS_FULL) begin
        bad_d = 1'b1;
      end else begin
        beat_wr = (cur_state == CAPTURE);
        if (beat_cnt_q == LAST_BEAT) begin
          beat_cnt_d = '0;
          row_cnt_d  = row_cnt_q + 1'b1;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
    end

    if (frame_ready_q && frame_release) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
    end

    // Completeness uses the post-beat counters so a coincident beat counts.
    if (rx_frame_end) begin
      complete = (row_cnt_d == ROWS_FULL) && (beat_cnt_d == '0) && !bad_d;
      if (complete && (cur_state == CAPTURE)) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end else if (complete) begin
        overrun_set = 1'b1;
      end else begin
        error_set = 1'b1;
      end
      started_d  = 1'b0;
      state_d    = CAPTURE;
      beat_cnt_d = '0;
      row_cnt_d  = '0;
      bad_d      = 1'b0;
    end

    overrun_d     = overrun_set ? 1'b1 : (clear_status ? 1'b0 : overrun_q);
    frame_error_d = error_set   ? 1'b1 : (clear_status ? 1'b0 : frame_error_q);
    frame_ready_d = full_d[rbank_d];

    rd_valid_d = rd_en && frame_ready_q;
    rd_data_d  = rd_valid_d ? bank_pix[rbank_q] : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= CAPTURE;
      started_q     <= 1'b0;
      beat_cnt_q    <= '0;
      row_cnt_q     <= '0;
      bad_q         <= 1'b0;
      wbank_q       <= 1'b0;
      rbank_q       <= 1'b0;
      full_q        <= '0;
      frame_ready_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      started_q     <= started_d;
      beat_cnt_q    <= beat_cnt_d;
      row_cnt_q     <= row_cnt_d;
      bad_q         <= bad_d;
      wbank_q       <= wbank_d;
      rbank_q       <= rbank_d;
      full_q        <= full_d;
      frame_ready_q <= frame_ready_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
      overrun_q     <= overrun_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign frame_ready = frame_ready_q;
  assign overrun     = overrun_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_sensor_frame_receiver.sv
// Directed bench for sensor_frame_receiver: reads push expected pixels into
// a queue that a negedge monitor pops whenever rd_valid is seen.
module tb_sensor_frame_receiver;
  import sensor_rx_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             rx_valid;
  logic [BUS_W-1:0] rx_data;
  logic             rx_frame_end;
  logic             rd_en;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  pixel_t           rd_data;
  logic             rd_valid;
  logic             frame_ready;
  logic             frame_release;
  logic             clear_status;
  logic             overrun;
  logic             frame_error;

  int               n_tests = 0;
  int               n_fail  = 0;
  logic [7:0]       exp_q[$];
  logic [7:0]       exp_v;

  sensor_frame_receiver dut (
    .clk           (clk),
    .reset         (reset),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_frame_end  (rx_frame_end),
    .rd_en         (rd_en),
    .rd_row        (rd_row),
    .rd_col        (rd_col),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .frame_ready   (frame_ready),
    .frame_release (frame_release),
    .clear_status  (clear_status),
    .overrun       (overrun),
    .frame_error   (frame_error)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [7:0] pix(int base, int r, int c);
    return 8'((base + r * ROW_PIXELS + c) & 255);
  endfunction

  task automatic chk(string name, int got, int expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(int base, int idx, bit fe, bit rel, bit clr);
    int r;
    int k;
    r = idx / BEATS;
    k = idx % BEATS;
    rx_valid = 1'b1;
    for (int i = 0; i < BUS_PIXELS; i++) begin
      rx_data[i*PIXEL_BITS +: PIXEL_BITS] = pix(base, r, k * BUS_PIXELS + i);
    end
    rx_frame_end  = fe;
    frame_release = rel;
    clear_status  = clr;
    step();
    rx_valid      = 1'b0;
    rx_frame_end  = 1'b0;
    frame_release = 1'b0;
    clear_status  = 1'b0;
  endtask

  task automatic send_frame(int base, int nbeats, bit end_on_last, bit rel_last, bit clr_last);
    for (int b = 0; b < nbeats; b++) begin
      send_beat(base, b, end_on_last && (b == nbeats - 1),
                rel_last && (b == nbeats - 1), clr_last && (b == nbeats - 1));
    end
    if (!end_on_last) begin
      rx_frame_end = 1'b1;
      step();
      rx_frame_end = 1'b0;
    end
  endtask

  task automatic rd(int r, int c, int expv, bit expect_valid, bit rel);
    rd_en         = 1'b1;
    rd_row        = ROW_W'(r);
    rd_col        = COL_W'(c);
    frame_release = rel;
    if (expect_valid) exp_q.push_back(8'(expv));
    step();
    rd_en         = 1'b0;
    frame_release = 1'b0;
  endtask

  task automatic pulse_release();
    frame_release = 1'b1;
    step();
    frame_release = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
  endtask

  task automatic check_flags(string tag, int ready, int ovr, int err);
    @(negedge clk);
    chk({tag, "_ready"},   int'(frame_ready), ready);
    chk({tag, "_overrun"}, int'(overrun),     ovr);
    chk({tag, "_error"},   int'(frame_error), err);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_rd_valid"},    int'(rd_valid),    0);
    chk({tag, "_rd_data"},     int'(rd_data),     0);
    chk({tag, "_frame_ready"}, int'(frame_ready), 0);
    chk({tag, "_overrun"},     int'(overrun),     0);
    chk({tag, "_frame_error"}, int'(frame_error), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rd_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got rd_valid with data %0d, expected no read response", rd_data);
      end else begin
        exp_v = exp_q.pop_front();
        if (rd_data !== exp_v) begin
          n_fail++;
          $display("FAIL rd_data: got %0d, expected %0d", rd_data, exp_v);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    rx_valid = 1'b0; rx_data = '0; rx_frame_end = 1'b0;
    rd_en = 1'b0; rd_row = '0; rd_col = '0;
    frame_release = 1'b0; clear_status = 1'b0;
    #12;
    check_all_zero("reset");
    step();
    reset = 1'b0;
    step();

    // 1: single frame into bank 0
    send_frame(0, 9, 1'b0, 1'b0, 1'b0);
    check_flags("t1", 1, 0, 0);
    rd(2, 23, 71, 1'b1, 1'b0);
    rd(0, 0, 0, 1'b1, 1'b0);
    rd(1, 5, 29, 1'b1, 1'b0);
    rd(3, 0, 0, 1'b1, 1'b0);
    rd(0, 24, 0, 1'b1, 1'b0);

    // 2: two frames fill both banks, third is dropped
    send_frame(100, 9, 1'b0, 1'b0, 1'b0);
    check_flags("t2_second", 1, 0, 0);
    send_frame(200, 9, 1'b0, 1'b0, 1'b0);
    check_flags("t2_third", 1, 1, 0);
    pulse_release();
    check_flags("t2_rel1", 1, 1, 0);
    rd(0, 0, 100, 1'b1, 1'b0);
    rd(2, 23, 171, 1'b1, 1'b0);
    pulse_release();
    check_flags("t2_rel2", 0, 1, 0);
    rd(1, 1, 0, 1'b0, 1'b0);
    pulse_clear();
    check_flags("t6_clear", 0, 0, 0);

    // 3: malformed frames
    send_frame(0, 8, 1'b0, 1'b0, 1'b0);
    check_flags("t3_short", 0, 0, 1);
    pulse_clear();
    check_flags("t3_clr1", 0, 0, 0);
    send_frame(0, 10, 1'b0, 1'b0, 1'b0);
    check_flags("t3_long", 0, 0, 1);
    pulse_clear();
    send_frame(50, 9, 1'b0, 1'b0, 1'b0);
    check_flags("t3_good", 1, 0, 0);
    rd(1, 7, 81, 1'b1, 1'b0);
    rd(2, 23, 121, 1'b1, 1'b0);
    rx_frame_end = 1'b1;
    step();
    rx_frame_end = 1'b0;
    check_flags("t3_empty", 1, 0, 1);
    pulse_clear();

    // 4a: last beat coincident with frame end, lands in bank 1
    send_frame(30, 9, 1'b1, 1'b0, 1'b0);
    check_flags("t4_coincident", 1, 0, 0);
    pulse_release();
    rd(2, 23, 101, 1'b1, 1'b0);
    rd(0, 3, 33, 1'b1, 1'b0);

    // 4b: commit into bank 0 and release of bank 1 in the same cycle
    send_frame(60, 9, 1'b1, 1'b1, 1'b0);
    check_flags("t4_commit_rel", 1, 0, 0);
    rd(0, 0, 60, 1'b1, 1'b0);
    rd(2, 23, 131, 1'b1, 1'b0);
    rd(1, 0, 84, 1'b1, 1'b1);
    check_flags("t4_read_rel", 0, 0, 0);

    // 5: reset in the middle of a frame
    for (int b = 0; b < 4; b++) send_beat(0, b, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    check_all_zero("t5_reset");
    step();
    reset = 1'b0;
    step();
    send_frame(10, 9, 1'b0, 1'b0, 1'b0);
    check_flags("t5_after", 1, 0, 0);
    rd(2, 23, 81, 1'b1, 1'b0);
    rd(0, 0, 10, 1'b1, 1'b0);

    // 6: overrun set coincident with clear_status wins
    send_frame(20, 9, 1'b0, 1'b0, 1'b0);
    check_flags("t6_fill", 1, 0, 0);
    send_frame(40, 9, 1'b1, 1'b0, 1'b1);
    check_flags("t6_set_vs_clr", 1, 1, 0);
    rd(0, 0, 10, 1'b1, 1'b0);
    pulse_clear();
    check_flags("t6_cleared", 1, 0, 0);

    step();
    step();
    chk("exp_q_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
